// File: rtl/param_shift_register_if.sv
// Bus bundle for param_shift_register: parallel load, shift command and result/handshake signals.
// The sequencer side drives requests through master; the shift register consumes them through slave.
interface param_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic [WIDTH-1:0] IN1;
  logic             LOAD_ENABLE;
  logic             START;
  logic [2:0]       MODE;
  logic [AMT_W-1:0] AMOUNT;
  logic             SERIAL_IN;
  logic [WIDTH-1:0] OUT;
  logic             FLAG;
  logic             BUSY;
  logic             DONE;
  logic             ZERO;

  modport master (
    output IN1, LOAD_ENABLE, START, MODE, AMOUNT, SERIAL_IN,
    input  OUT, FLAG, BUSY, DONE, ZERO
  );

  modport slave (
    input  IN1, LOAD_ENABLE, START, MODE, AMOUNT, SERIAL_IN,
    output OUT, FLAG, BUSY, DONE, ZERO
  );
endinterface

// File: rtl/param_shift_register.sv
// WIDTH-bit register with parallel load and a multi-step shift/rotate engine.
// A START runs AMOUNT single-bit steps, one per clock, under a BUSY/DONE handshake.
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  param_shift_register_if.slave bus
);

  localparam logic [2:0] MODE_LSL = 3'b001;
  localparam logic [2:0] MODE_LSR = 3'b010;
  localparam logic [2:0] MODE_ASR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;

  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_nxt_s;
  logic             flag_r;
  logic             flag_nxt_s;
  logic [2:0]       mode_r;
  logic [2:0]       mode_nxt_s;
  logic [AMT_W-1:0] cnt_r;
  logic [AMT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] step_out_s;
  logic             step_flag_s;
  logic             accept_s;
  logic             busy_s;
  logic             done_s;

  // New commands are only taken while not stepping (IDLE or FIN).
  assign accept_s = (state_r != SHIFT);

  // State and datapath registers; RESET abandons any operation in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      out_r   <= {WIDTH{1'b0}};
      flag_r  <= 1'b0;
      mode_r  <= 3'b000;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      flag_r  <= flag_nxt_s;
      mode_r  <= mode_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: load beats start, AMOUNT=0 skips straight to FIN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, FIN: begin
        if (bus.LOAD_ENABLE) begin
          state_nxt_s = IDLE;
        end else if (bus.START) begin
          state_nxt_s = (bus.AMOUNT == CNT_ZERO) ? FIN : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Single-bit step result for the latched mode.
  always_comb begin
    step_out_s  = out_r;
    step_flag_s = flag_r;
    case (mode_r)
      MODE_LSL: begin
        step_out_s  = {out_r[WIDTH-2:0], bus.SERIAL_IN};
        step_flag_s = out_r[WIDTH-1];
      end
      MODE_LSR: begin
        step_out_s  = {bus.SERIAL_IN, out_r[WIDTH-1:1]};
        step_flag_s = out_r[0];
      end
      MODE_ASR: begin
        step_out_s  = {out_r[WIDTH-1], out_r[WIDTH-1:1]};
        step_flag_s = out_r[0];
      end
      MODE_ROL: begin
        step_out_s  = {out_r[WIDTH-2:0], out_r[WIDTH-1]};
        step_flag_s = out_r[WIDTH-1];
      end
      MODE_ROR: begin
        step_out_s  = {out_r[0], out_r[WIDTH-1:1]};
        step_flag_s = out_r[0];
      end
      default: begin
        step_out_s  = out_r;
        step_flag_s = flag_r;
      end
    endcase
  end

  // Datapath next values: accept load/start when idle, otherwise run one step.
  always_comb begin
    out_nxt_s  = out_r;
    flag_nxt_s = flag_r;
    mode_nxt_s = mode_r;
    cnt_nxt_s  = cnt_r;
    if (accept_s) begin
      if (bus.LOAD_ENABLE) begin
        out_nxt_s  = bus.IN1;
        flag_nxt_s = 1'b0;
      end else if (bus.START) begin
        mode_nxt_s = bus.MODE;
        cnt_nxt_s  = bus.AMOUNT;
        flag_nxt_s = 1'b0;
      end else begin
        out_nxt_s  = out_r;
        flag_nxt_s = flag_r;
      end
    end else begin
      out_nxt_s  = step_out_s;
      flag_nxt_s = step_flag_s;
      cnt_nxt_s  = cnt_r - CNT_ONE;
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      SHIFT:   busy_s = 1'b1;
      FIN:     done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  assign bus.OUT  = out_r;
  assign bus.FLAG = flag_r;
  assign bus.BUSY = busy_s;
  assign bus.DONE = done_s;
  assign bus.ZERO = (out_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register (WIDTH=8, AMT_W=3).
module tb_param_shift_register;
  logic CLK;
  logic RESET;
  int   passed;
  int   total;
  int   busy_n;
  int   cyc;

  param_shift_register_if #(.WIDTH(8), .AMT_W(3)) bus ();

  param_shift_register #(.WIDTH(8), .AMT_W(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue START, then wait (bounded) for DONE; reports cycles with BUSY and edges to DONE.
  task automatic do_op(input logic [2:0] m, input logic [2:0] a, input logic si,
                       output int bn, output int cy);
    bus.START     = 1'b1;
    bus.MODE      = m;
    bus.AMOUNT    = a;
    bus.SERIAL_IN = si;
    step();
    bus.START = 1'b0;
    cy = 1;
    bn = 0;
    while (bus.DONE !== 1'b1 && cy < 40) begin
      if (bus.BUSY === 1'b1) bn++;
      step();
      cy++;
    end
    chk("done_seen", bus.DONE, 1'b1);
  endtask

  task automatic load(input logic [7:0] v);
    bus.LOAD_ENABLE = 1'b1;
    bus.IN1         = v;
    step();
    bus.LOAD_ENABLE = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    RESET  = 1'b1;
    bus.IN1 = 8'hAA;
    bus.LOAD_ENABLE = 1'b1;
    bus.START = 1'b1;
    bus.MODE = 3'b001;
    bus.AMOUNT = 3'd3;
    bus.SERIAL_IN = 1'b0;
    step();
    step();
    chk("rst_out", bus.OUT, 8'h00);
    chk("rst_flag", bus.FLAG, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    chk("rst_zero", bus.ZERO, 1'b1);
    RESET = 1'b0;
    bus.LOAD_ENABLE = 1'b0;
    bus.START = 1'b0;

    // LSL by 3
    load(8'hB5);
    chk("load_out", bus.OUT, 8'hB5);
    chk("load_zero", bus.ZERO, 1'b0);
    do_op(3'b001, 3'd3, 1'b0, busy_n, cyc);
    chk("lsl_busy_cycles", busy_n, 3);
    chk("lsl_latency", cyc, 4);
    chk("lsl_out", bus.OUT, 8'hA8);
    chk("lsl_flag", bus.FLAG, 1'b1);
    chk("lsl_done_busy", bus.BUSY, 1'b0);
    step();
    chk("lsl_done_pulse", bus.DONE, 1'b0);

    // ASR by 2, then LSR by 1 filling with 1
    load(8'h90);
    do_op(3'b011, 3'd2, 1'b0, busy_n, cyc);
    chk("asr_out", bus.OUT, 8'hE4);
    chk("asr_flag", bus.FLAG, 1'b0);
    step();
    do_op(3'b010, 3'd1, 1'b1, busy_n, cyc);
    chk("lsr_out", bus.OUT, 8'hF2);
    chk("lsr_flag", bus.FLAG, 1'b0);
    step();

    // ROR by 1 then back-to-back ROL by 1 from the DONE cycle
    load(8'h03);
    do_op(3'b101, 3'd1, 1'b0, busy_n, cyc);
    chk("ror_out", bus.OUT, 8'h81);
    chk("ror_flag", bus.FLAG, 1'b1);
    do_op(3'b100, 3'd1, 1'b0, busy_n, cyc);
    chk("b2b_latency", cyc, 2);
    chk("rol_out", bus.OUT, 8'h03);
    chk("rol_flag", bus.FLAG, 1'b1);
    step();

    // Busy interlock: START/LOAD mid-operation are ignored
    load(8'hFF);
    bus.START = 1'b1;
    bus.MODE = 3'b010;
    bus.AMOUNT = 3'd7;
    bus.SERIAL_IN = 1'b0;
    step();
    bus.START = 1'b0;
    step();
    bus.START = 1'b1;
    bus.LOAD_ENABLE = 1'b1;
    bus.IN1 = 8'h55;
    bus.MODE = 3'b100;
    bus.AMOUNT = 3'd1;
    step();
    bus.START = 1'b0;
    bus.LOAD_ENABLE = 1'b0;
    chk("intlk_busy", bus.BUSY, 1'b1);
    cyc = 3;
    while (bus.DONE !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("intlk_latency", cyc, 8);
    chk("intlk_out", bus.OUT, 8'h01);
    chk("intlk_flag", bus.FLAG, 1'b1);
    step();
    chk("intlk_single_done", bus.DONE, 1'b0);
    step();
    chk("intlk_no_queue_done", bus.DONE, 1'b0);
    chk("intlk_no_queue_out", bus.OUT, 8'h01);

    // AMOUNT=0: DONE next cycle, no BUSY, OUT kept, FLAG cleared
    do_op(3'b001, 3'd0, 1'b1, busy_n, cyc);
    chk("amt0_latency", cyc, 1);
    chk("amt0_busy", busy_n, 0);
    chk("amt0_busy_now", bus.BUSY, 1'b0);
    chk("amt0_out", bus.OUT, 8'h01);
    chk("amt0_flag", bus.FLAG, 1'b0);
    step();

    // LOAD and START together: load only
    bus.LOAD_ENABLE = 1'b1;
    bus.START = 1'b1;
    bus.IN1 = 8'h3C;
    bus.MODE = 3'b001;
    bus.AMOUNT = 3'd2;
    step();
    bus.LOAD_ENABLE = 1'b0;
    bus.START = 1'b0;
    chk("ldst_out", bus.OUT, 8'h3C);
    chk("ldst_busy", bus.BUSY, 1'b0);
    chk("ldst_done", bus.DONE, 1'b0);
    step();
    chk("ldst_done_later", bus.DONE, 1'b0);
    chk("ldst_out_later", bus.OUT, 8'h3C);

    // RESET two steps into a 5-step LSL
    bus.START = 1'b1;
    bus.MODE = 3'b001;
    bus.AMOUNT = 3'd5;
    bus.SERIAL_IN = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    step();
    chk("mid_busy_pre", bus.BUSY, 1'b1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_out", bus.OUT, 8'h00);
    chk("mid_rst_busy", bus.BUSY, 1'b0);
    chk("mid_rst_zero", bus.ZERO, 1'b1);
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) busy_n++;
      step();
    end
    chk("mid_rst_no_done", busy_n, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
